// File: rtl/operand_fetch_stage.sv
// RV32I operand-fetch stage: RAW bypass/stall resolution into the ID/EX register. OFS_FORWARDING_EN enables the EX/MEM/WB bypass.
// Latency 1 cycle; in_ready drops on load-use (or any EX/MEM dependency without bypass), flush, or a held entry EX won't take.
module operand_fetch_stage #(
  parameter int CTRL_W = 16,
  parameter int PC_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [4:0]        in_rd,
  input  logic              in_uses_rs1,
  input  logic              in_uses_rs2,
  input  logic              in_wen,
  input  logic              in_is_load,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic [4:0]        rf_rs1,
  output logic [4:0]        rf_rs2,
  input  logic [31:0]       rf_rdata1,
  input  logic [31:0]       rf_rdata2,
  input  logic [31:0]       ex_result,
  input  logic              mem_wen,
  input  logic [4:0]        mem_rd,
  input  logic [31:0]       mem_data,
  input  logic              wb_wen,
  input  logic [4:0]        wb_rd,
  input  logic [31:0]       wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [31:0]       out_rs1_val,
  output logic [31:0]       out_rs2_val,
  output logic [4:0]        out_rd,
  output logic              out_wen,
  output logic              out_is_load,
  output logic [CTRL_W-1:0] out_ctrl
);

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [31:0]       rs1_val;
    logic [31:0]       rs2_val;
    logic [4:0]        rd;
    logic              wen;
    logic              is_load;
    logic [CTRL_W-1:0] ctrl;
  } idex_t;

  idex_t       idex_q;
  idex_t       idex_d;
  logic        ex_m1, ex_m2, mem_m1, mem_m2;
  logic        stall, transfer;
  logic [31:0] op1, op2;

  function automatic logic src_match(input logic uses, input logic wen,
                                     input logic [4:0] rd, input logic [4:0] rs);
    return uses && wen && (rd == rs) && (rs != 5'd0);
  endfunction

  assign rf_rs1 = in_rs1;
  assign rf_rs2 = in_rs2;

  // The held entry only counts as a producer while it is actually valid.
  assign ex_m1  = src_match(in_uses_rs1, out_valid && idex_q.wen, idex_q.rd, in_rs1);
  assign ex_m2  = src_match(in_uses_rs2, out_valid && idex_q.wen, idex_q.rd, in_rs2);
  assign mem_m1 = src_match(in_uses_rs1, mem_wen, mem_rd, in_rs1);
  assign mem_m2 = src_match(in_uses_rs2, mem_wen, mem_rd, in_rs2);

`ifdef OFS_FORWARDING_EN
  logic wb_m1, wb_m2;

  assign wb_m1 = src_match(in_uses_rs1, wb_wen, wb_rd, in_rs1);
  assign wb_m2 = src_match(in_uses_rs2, wb_wen, wb_rd, in_rs2);

  // A load in EX has no data yet; wait one cycle and pick it up from MEM.
  assign stall = (ex_m1 || ex_m2) && idex_q.is_load;

  function automatic logic [31:0] pick(input logic [4:0] rs, input logic ex_m,
                                       input logic mem_m, input logic wb_m,
                                       input logic ex_is_load, input logic [31:0] rf,
                                       input logic [31:0] ex_v, input logic [31:0] mem_v,
                                       input logic [31:0] wb_v);
    logic [31:0] v;
    v = rf;
    if (rs == 5'd0)              v = 32'd0;
    else if (ex_m && !ex_is_load) v = ex_v;
    else if (mem_m)               v = mem_v;
    else if (wb_m)                v = wb_v;
    return v;
  endfunction

  assign op1 = pick(in_rs1, ex_m1, mem_m1, wb_m1, idex_q.is_load, rf_rdata1,
                    ex_result, mem_data, wb_data);
  assign op2 = pick(in_rs2, ex_m2, mem_m2, wb_m2, idex_q.is_load, rf_rdata2,
                    ex_result, mem_data, wb_data);
`else
  logic unused_bypass_inputs;

  // WB needs no check: the register file writes on the falling edge.
  assign stall = ex_m1 || ex_m2 || mem_m1 || mem_m2;
  assign op1   = (in_rs1 == 5'd0) ? 32'd0 : rf_rdata1;
  assign op2   = (in_rs2 == 5'd0) ? 32'd0 : rf_rdata2;
  assign unused_bypass_inputs = ^{ex_result, mem_data, wb_wen, wb_rd, wb_data};
`endif

  assign in_ready = !stall && !flush && (!out_valid || out_ready);
  assign transfer = in_valid && in_ready;

  always_comb begin
    idex_d         = idex_q;
    idex_d.pc      = in_pc;
    idex_d.rs1_val = op1;
    idex_d.rs2_val = op2;
    idex_d.rd      = in_rd;
    idex_d.wen     = in_wen;
    idex_d.is_load = in_is_load;
    idex_d.ctrl    = in_ctrl;
  end

  // Payload holds on flush/drain; only the valid bit is cleared.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      idex_q    <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (transfer) begin
      out_valid <= 1'b1;
      idex_q    <= idex_d;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign out_pc      = idex_q.pc;
  assign out_rs1_val = idex_q.rs1_val;
  assign out_rs2_val = idex_q.rs2_val;
  assign out_rd      = idex_q.rd;
  assign out_wen     = idex_q.wen;
  assign out_is_load = idex_q.is_load;
  assign out_ctrl    = idex_q.ctrl;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Scoreboard bench for operand_fetch_stage; expectations follow OFS_FORWARDING_EN when defined.
module tb_operand_fetch_stage;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready;
  logic [31:0] in_pc;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic        in_uses_rs1, in_uses_rs2, in_wen, in_is_load;
  logic [15:0] in_ctrl;
  logic [4:0]  rf_rs1, rf_rs2;
  logic [31:0] rf_rdata1, rf_rdata2, ex_result;
  logic        mem_wen, wb_wen;
  logic [4:0]  mem_rd, wb_rd;
  logic [31:0] mem_data, wb_data;
  logic        out_valid, out_ready;
  logic [31:0] out_pc, out_rs1_val, out_rs2_val;
  logic [4:0]  out_rd;
  logic        out_wen, out_is_load;
  logic [15:0] out_ctrl;

  typedef struct packed {
    logic [31:0] pc, v1, v2;
    logic [4:0]  rd;
    logic        w, ld;
    logic [15:0] ctrl;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] exp1, exp2, t5_v1;
  int          n_checks = 0;
  int          n_pass   = 0;

  operand_fetch_stage #(.CTRL_W(16), .PC_W(32)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_uses_rs1(in_uses_rs1), .in_uses_rs2(in_uses_rs2),
    .in_wen(in_wen), .in_is_load(in_is_load), .in_ctrl(in_ctrl),
    .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .ex_result(ex_result),
    .mem_wen(mem_wen), .mem_rd(mem_rd), .mem_data(mem_data),
    .wb_wen(wb_wen), .wb_rd(wb_rd), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val), .out_rd(out_rd),
    .out_wen(out_wen), .out_is_load(out_is_load), .out_ctrl(out_ctrl)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rf_val(input logic [4:0] a);
    return {8'h10, 3'b000, a, 8'h00, 3'b000, a};
  endfunction

  always_comb begin
    rf_rdata1 = rf_val(rf_rs1);
    rf_rdata2 = rf_val(rf_rs2);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ins(input logic [31:0] pc, input logic [4:0] r1, input logic [4:0] r2,
                         input logic [4:0] rd, input logic u1, input logic u2,
                         input logic w, input logic ld,
                         input logic [31:0] e1, input logic [31:0] e2);
    in_valid = 1'b1; in_pc = pc; in_rs1 = r1; in_rs2 = r2; in_rd = rd;
    in_uses_rs1 = u1; in_uses_rs2 = u2; in_wen = w; in_is_load = ld;
    in_ctrl = pc[15:0] ^ 16'h5A5A;
    exp1 = e1; exp2 = e2;
  endtask

  // Consume on the EX handshake, record on the input handshake.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_pc",   out_pc, e.pc);
        check("sb_rs1",  out_rs1_val, e.v1);
        check("sb_rs2",  out_rs2_val, e.v2);
        check("sb_rd",   32'(out_rd), 32'(e.rd));
        check("sb_flag", 32'({out_wen, out_is_load}), 32'({e.w, e.ld}));
        check("sb_ctrl", 32'(out_ctrl), 32'(e.ctrl));
      end
    end
    if (!reset && in_valid && in_ready)
      sb.push_back('{pc: in_pc, v1: exp1, v2: exp2, rd: in_rd, w: in_wen, ld: in_is_load,
                     ctrl: in_ctrl});
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, 0 required");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_pc = '0;
    in_rs1 = '0; in_rs2 = '0; in_rd = '0; in_uses_rs1 = 1'b0; in_uses_rs2 = 1'b0;
    in_wen = 1'b0; in_is_load = 1'b0; in_ctrl = '0; ex_result = '0;
    mem_wen = 1'b0; mem_rd = '0; mem_data = '0; wb_wen = 1'b0; wb_rd = '0; wb_data = '0;
    out_ready = 1'b1; exp1 = '0; exp2 = '0; t5_v1 = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_pc", out_pc, 32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);
    tick();

    // ADD x5,x1,x2
    set_ins(32'h100, 5'd1, 5'd2, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, rf_val(5'd1), rf_val(5'd2));
    @(negedge clk); check("t1_ready", 32'(in_ready), 32'd1);
    tick();

    // ADD x6,x5,x5 directly behind its producer
    ex_result = 32'h0000_1234;
    set_ins(32'h104, 5'd5, 5'd5, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0, 32'h1234, 32'h1234);
`ifdef OFS_FORWARDING_EN
    @(negedge clk); check("t2_no_bubble", 32'(in_ready), 32'd1);
    tick();
`else
    @(negedge clk); check("t2_stall_ex", 32'(in_ready), 32'd0);
    tick();
    mem_wen = 1'b1; mem_rd = 5'd5; mem_data = 32'h1234;
    @(negedge clk); check("t2_stall_mem", 32'(in_ready), 32'd0);
    tick();
    mem_wen = 1'b0; wb_wen = 1'b1; wb_rd = 5'd5; wb_data = 32'h1234;
    exp1 = rf_val(5'd5); exp2 = rf_val(5'd5);
    @(negedge clk); check("t2_resume", 32'(in_ready), 32'd1);
    tick();
    wb_wen = 1'b0;
`endif

    // LW x7 (rs2 unused)
    set_ins(32'h108, 5'd1, 5'd0, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1, rf_val(5'd1), 32'd0);
    @(negedge clk); check("t3_ready", 32'(in_ready), 32'd1);
    tick();

    // ADD x0,x7,x0: load-use
    set_ins(32'h10C, 5'd7, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 32'hDEAD_BEEF, 32'd0);
    @(negedge clk); check("t4_loaduse", 32'(in_ready), 32'd0);
    tick();
    mem_wen = 1'b1; mem_rd = 5'd7; mem_data = 32'hDEAD_BEEF;
`ifdef OFS_FORWARDING_EN
    @(negedge clk);
    check("t4_bubble", 32'(out_valid), 32'd0);
    check("t4_resume", 32'(in_ready), 32'd1);
    tick();
    mem_wen = 1'b0;
`else
    @(negedge clk);
    check("t4_bubble", 32'(out_valid), 32'd0);
    check("t4_stall_mem", 32'(in_ready), 32'd0);
    tick();
    mem_wen = 1'b0; wb_wen = 1'b1; wb_rd = 5'd7; wb_data = 32'hDEAD_BEEF;
    exp1 = rf_val(5'd7);
    @(negedge clk); check("t4_resume", 32'(in_ready), 32'd1);
    tick();
    wb_wen = 1'b0;
`endif

    // MEM and WB both write x3; x0 source while held entry writes x0
    ex_result = 32'h0000_EEEE;
    mem_wen = 1'b1; mem_rd = 5'd3; mem_data = 32'hA;
    wb_wen  = 1'b1; wb_rd  = 5'd3; wb_data  = 32'hB;
    set_ins(32'h110, 5'd3, 5'd0, 5'd12, 1'b1, 1'b1, 1'b1, 1'b0, 32'hA, 32'd0);
`ifdef OFS_FORWARDING_EN
    t5_v1 = 32'hA;
    @(negedge clk); check("t5_ready", 32'(in_ready), 32'd1);
    tick();
`else
    @(negedge clk); check("t5_stall_mem", 32'(in_ready), 32'd0);
    tick();
    mem_wen = 1'b0;
    exp1 = rf_val(5'd3); t5_v1 = rf_val(5'd3);
    @(negedge clk); check("t5_wb_nostall", 32'(in_ready), 32'd1);
    tick();
`endif
    mem_wen = 1'b0; wb_wen = 1'b0;

    // Backpressure; rs2 names the held rd but is unused
    out_ready = 1'b0;
    set_ins(32'h114, 5'd9, 5'd12, 5'd11, 1'b1, 1'b0, 1'b1, 1'b0, rf_val(5'd9), rf_val(5'd12));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_ready", 32'(in_ready), 32'd0);
      check("bp_pc", out_pc, 32'h110);
      check("bp_rs1", out_rs1_val, t5_v1);
      tick();
    end
    out_ready = 1'b1;
    @(negedge clk); check("bp_release", 32'(in_ready), 32'd1);
    tick();

    // Flush kills the incoming instruction
    set_ins(32'h118, 5'd14, 5'd15, 5'd16, 1'b1, 1'b1, 1'b1, 1'b0, rf_val(5'd14), rf_val(5'd15));
    flush = 1'b1;
    @(negedge clk); check("flush_ready", 32'(in_ready), 32'd0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("flush_valid", 32'(out_valid), 32'd0);
    check("flush_hold_pc", out_pc, 32'h114);
    tick();

    // Reset while an entry is held under backpressure
    set_ins(32'h11C, 5'd16, 5'd17, 5'd18, 1'b1, 1'b1, 1'b1, 1'b1, rf_val(5'd16), rf_val(5'd17));
    @(negedge clk); check("t8_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    tick();
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    reset = 1'b1;
    #1;
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_pc", out_pc, 32'd0);
    check("arst_ops", out_rs1_val | out_rs2_val, 32'd0);
    check("arst_fields", 32'({out_rd, out_wen, out_is_load, out_ctrl}), 32'd0);
    #1 reset = 1'b0;
    sb.delete();
    out_ready = 1'b1;
    tick();
    @(negedge clk);
    check("post_rst_valid", 32'(out_valid), 32'd0);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/operand_fetch_stage.md
Name:
operand_fetch_stage

Overview:
- Decode/operand-fetch stage of the RV32I pipeline.
- Drives the register file read addresses and reads back the asynchronous read data.
- Resolves RAW hazards by bypassing from EX, MEM and WB, or by stalling on load-use.
- Registers the instruction and its operands into the ID/EX pipeline register using a valid/ready handshake.

Parameters:
CTRL_W, 16, width of the opaque decoded-control bundle carried to EX
PC_W, 32, program counter width

Ports:
clk  input  1  clock, rising-edge pipeline register
reset  input  1  reset, asynchronous, active-high
flush  input  1  synchronous kill of the stage (branch/jump redirect)
in_valid  input  1  decoded instruction present
in_ready  output  1  stage accepts the instruction this cycle
in_pc  input  PC_W  instruction PC
in_rs1, in_rs2, in_rd  input  5  register indices
in_uses_rs1, in_uses_rs2  input  1  operand actually read
in_wen  input  1  instruction writes rd
in_is_load  input  1  instruction is a load
in_ctrl  input  CTRL_W  decoded control bundle
rf_rs1, rf_rs2  output  5  register file read addresses (= in_rs1/in_rs2, combinational)
rf_rdata1, rf_rdata2  input  32  register file read data
ex_result  input  32  combinational EX result of the instruction held in the output register
mem_wen  input  1  MEM stage writes rd
mem_rd  input  5  MEM destination
mem_data  input  32  MEM final value (load data resolved)
wb_wen  input  1  WB stage writes rd
wb_rd  input  5  WB destination
wb_data  input  32  WB value
out_valid  output  1  ID/EX register holds a valid instruction
out_ready  input  1  EX consumes the held instruction
out_pc  output  PC_W  registered PC
out_rs1_val, out_rs2_val  output  32  registered resolved operands
out_rd  output  5  registered rd
out_wen, out_is_load  output  1  registered flags
out_ctrl  output  CTRL_W  registered control bundle

Behaviour:
- Reset: out_valid=0; out_pc, out_rs*_val, out_rd, out_ctrl = 0; out_wen=0; out_is_load=0. Asynchronous, takes effect immediately, including mid-stall.
- A source sN is a match against a producer P when all hold: in_uses_rsN, P.wen, P.rd==in_rsN, in_rsN!=0.
- Load-use stall: a source matches the held entry (out_valid && out_wen) while out_is_load=1.
- Operand select when not stalled, priority high to low:
  1. rsN==0 -> 0
  2. EX match (held entry, non-load) -> ex_result
  3. MEM match -> mem_data
  4. WB match -> wb_data
  5. otherwise rf_rdata.
- in_ready = !stall && !flush && (!out_valid || out_ready).
- Transfer occurs when in_valid && in_ready. On transfer, the next edge loads all out_* fields with the resolved operands and sets out_valid=1.
- When out_ready && !transfer, out_valid clears at the next edge and the fields hold their values.
- When out_valid && !out_ready, all out_* fields hold (backpressure).
- Load-use costs exactly one bubble:
  - Cycle with the load in EX: in_ready=0; out_valid drops if the load is consumed.
  - Next cycle: the load is in MEM and its data is forwarded from mem_data.
- flush has highest priority: no transfer that cycle; out_valid=0 at the next edge.
- Simultaneous flush and out_ready: flush wins; the held entry is still consumed by EX (upstream handles the kill).
- Stall and flush are evaluated every cycle. Sources that are not used never cause a stall.
- Latency: 1 cycle from accepted input to out_valid.

Optional Feature:
Macro OFS_FORWARDING_EN.
- Defined: bypass network as described above.
- Undefined:
  - No EX/MEM/WB bypass; operands always come from rf_rdata, with rsN==0 -> 0.
  - The stall condition becomes: any source match against the held entry or MEM.
  - WB is not checked, because the register file writes on the falling edge, so rf_rdata is current before the rising edge.

Test Plan:
- Reset pulse with out_valid=1 and held data -> out_valid=0 and all out_* fields 0 immediately, before any clock edge.
- Back-to-back producer/consumer: ADD x5 (ex_result=0x1234) followed by ADD x6,x5,x5 -> out_rs1_val = out_rs2_val = 0x00001234, no bubble.
- Load-use: LW x7 held, next instruction uses x7 -> in_ready=0 for 1 cycle; after that, mem_data=0xDEADBEEF is forwarded into out_rs1_val.
- Priority: MEM and WB both write x3 (mem_data=0xA, wb_data=0xB); consumer reads x3 -> out_rs1_val = 0xA. Source x0 with a producer matching x0 -> 0.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and out_* stable; out_ready=1 -> transfer next edge.
- flush during a valid transfer attempt -> no transfer; out_valid=0 next edge. With OFS_FORWARDING_EN undefined, an EX dependency stalls 1 cycle and a MEM dependency stalls 1 more.
